// File: rtl/qerv_lsu.sv
// Nibble-serial load/store unit: gathers serial store data, runs one 32-bit data-bus
// transaction, and streams the aligned, extended load result back one slice per cycle.
module qerv_lsu #(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_we,
    input  logic [1:0]                i_size,
    input  logic                      i_signed,
    input  logic [1:0]                i_lsb,
    input  logic [31:0]               i_adr,
    input  logic                      i_en,
    input  logic [BITS_PER_CYCLE-1:0] i_rs2,
    output logic [31:0]               o_dbus_adr,
    output logic [31:0]               o_dbus_dat,
    output logic [3:0]                o_dbus_sel,
    output logic                      o_dbus_we,
    output logic                      o_dbus_cyc,
    input  logic [31:0]               i_dbus_rdt,
    input  logic                      i_dbus_ack,
    output logic [BITS_PER_CYCLE-1:0] o_rd,
    output logic                      o_rd_valid,
    output logic                      o_misalign,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = BITS_PER_CYCLE;
    localparam int unsigned CW   = 3;
    localparam int unsigned SELW = 4;

    localparam logic [1:0]    SZ_BYTE  = 2'b00;
    localparam logic [1:0]    SZ_HALF  = 2'b01;
    localparam logic [CW-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_BUS   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_data;
    logic [XLEN-1:0]   r_adr;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_lsb;
    logic              r_ext;
    logic              r_cyc;
    logic              r_dbus_we;
    logic [SELW-1:0]   r_sel;
    logic [XLEN-1:0]   r_dat;
    logic              r_done;
    logic              r_misalign;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [XLEN-1:0]   w_data_nxt;
    logic [XLEN-1:0]   w_adr_nxt;
    logic              w_we_nxt;
    logic [1:0]        w_size_nxt;
    logic              w_signed_nxt;
    logic [1:0]        w_lsb_nxt;
    logic              w_ext_nxt;
    logic              w_cyc_nxt;
    logic              w_dbus_we_nxt;
    logic [SELW-1:0]   w_sel_nxt;
    logic [XLEN-1:0]   w_dat_nxt;
    logic              w_done_nxt;
    logic              w_misalign_nxt;

    logic [XLEN-1:0]   w_fill_data;
    logic [XLEN-1:0]   w_rdt_aligned;
    logic              w_ack_ext;
    logic              w_start_misaligned;
    logic              w_slice_real;
    logic              w_unused;

    // Byte enables for the addressed lane(s).
    function automatic logic [SELW-1:0] f_sel(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: f_sel = SELW'(4'b0001 << lsb);
            SZ_HALF: f_sel = lsb[1] ? 4'b1100 : 4'b0011;
            default: f_sel = 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the slave picks it up from any lane.
    function automatic logic [XLEN-1:0] f_dat(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            SZ_BYTE: f_dat = {4{data[7:0]}};
            SZ_HALF: f_dat = {2{data[15:0]}};
            default: f_dat = data;
        endcase
    endfunction

    assign w_unused           = ^i_adr[1:0];
    assign w_fill_data        = {i_rs2, r_data[XLEN-1:SW]};
    assign w_rdt_aligned      = i_dbus_rdt >> {r_lsb, 3'b000};
    assign w_start_misaligned = ((i_size == SZ_HALF) & i_lsb[0]) | (i_size[1] & (i_lsb != 2'b00));

    // Extension bit is taken from the aligned value at ack, before the drain shifts it out.
    assign w_ack_ext = r_signed & ((r_size == SZ_BYTE) ? w_rdt_aligned[7]  :
                                   (r_size == SZ_HALF) ? w_rdt_aligned[15] : 1'b0);

    assign w_slice_real = (r_size == SZ_BYTE) ? (r_cnt < CW'(2)) :
                          (r_size == SZ_HALF) ? (r_cnt < CW'(4)) : 1'b1;

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_data_nxt     = r_data;
        w_adr_nxt      = r_adr;
        w_we_nxt       = r_we;
        w_size_nxt     = r_size;
        w_signed_nxt   = r_signed;
        w_lsb_nxt      = r_lsb;
        w_ext_nxt      = r_ext;
        w_cyc_nxt      = r_cyc;
        w_dbus_we_nxt  = r_dbus_we;
        w_sel_nxt      = r_sel;
        w_dat_nxt      = r_dat;
        w_done_nxt     = 1'b0;
        w_misalign_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_start_misaligned) begin
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_adr_nxt    = {i_adr[XLEN-1:2], 2'b00};
                        w_we_nxt     = i_we;
                        w_size_nxt   = i_size;
                        w_signed_nxt = i_signed;
                        w_lsb_nxt    = i_lsb;
                        w_cnt_nxt    = '0;
                        if (i_we) begin
                            w_state_nxt = S_FILL;
                        end else begin
                            w_state_nxt   = S_BUS;
                            w_cyc_nxt     = 1'b1;
                            w_dbus_we_nxt = 1'b0;
                            w_sel_nxt     = f_sel(i_size, i_lsb);
                        end
                    end
                end
            end

            S_FILL: begin
                if (i_en) begin
                    w_data_nxt = w_fill_data;
                    w_cnt_nxt  = r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt   = S_BUS;
                        w_cyc_nxt     = 1'b1;
                        w_dbus_we_nxt = r_we;
                        w_sel_nxt     = f_sel(r_size, r_lsb);
                        w_dat_nxt     = f_dat(r_size, w_fill_data);
                    end
                end
            end

            S_BUS: begin
                if (i_dbus_ack) begin
                    w_cyc_nxt     = 1'b0;
                    w_dbus_we_nxt = 1'b0;
                    w_sel_nxt     = '0;
                    if (r_we) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_data_nxt  = w_rdt_aligned;
                        w_ext_nxt   = w_ack_ext;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            S_DRAIN: begin
                if (i_en) begin
                    w_data_nxt = r_data >> SW;
                    w_cnt_nxt  = r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_adr      <= '0;
            r_we       <= 1'b0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            r_lsb      <= '0;
            r_ext      <= 1'b0;
            r_cyc      <= 1'b0;
            r_dbus_we  <= 1'b0;
            r_sel      <= '0;
            r_dat      <= '0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data     <= w_data_nxt;
            r_adr      <= w_adr_nxt;
            r_we       <= w_we_nxt;
            r_size     <= w_size_nxt;
            r_signed   <= w_signed_nxt;
            r_lsb      <= w_lsb_nxt;
            r_ext      <= w_ext_nxt;
            r_cyc      <= w_cyc_nxt;
            r_dbus_we  <= w_dbus_we_nxt;
            r_sel      <= w_sel_nxt;
            r_dat      <= w_dat_nxt;
            r_done     <= w_done_nxt;
            r_misalign <= w_misalign_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_dbus_adr = r_adr;
    assign o_dbus_dat = r_dat;
    assign o_dbus_sel = r_sel;
    assign o_dbus_we  = r_dbus_we;
    assign o_dbus_cyc = r_cyc;
    assign o_misalign = r_misalign;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

    // The result slice is handed over in the same cycle the register file enables it.
    assign o_rd_valid = (r_state == S_DRAIN) & i_en;
    assign o_rd       = o_rd_valid ? (w_slice_real ? r_data[SW-1:0] : {SW{r_ext}}) : '0;

endmodule

// File: tb/tb_qerv_lsu.sv
// Self-checking bench for qerv_lsu: directed plan cases plus randomized transactions
// checked against a word-level reference of the load/store rules.
module tb_qerv_lsu;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'b00;
    logic        i_signed = 1'b0;
    logic [1:0]  i_lsb = 2'b00;
    logic [31:0] i_adr = 32'h0;
    logic        i_en = 1'b0;
    logic [3:0]  i_rs2 = 4'h0;
    logic [31:0] o_dbus_adr;
    logic [31:0] o_dbus_dat;
    logic [3:0]  o_dbus_sel;
    logic        o_dbus_we;
    logic        o_dbus_cyc;
    logic [31:0] i_dbus_rdt = 32'h0;
    logic        i_dbus_ack = 1'b0;
    logic [3:0]  o_rd;
    logic        o_rd_valid;
    logic        o_misalign;
    logic        o_busy;
    logic        o_done;

    int nchecks = 0;
    int nfail   = 0;

    always #5 clk = ~clk;

    qerv_lsu #(.BITS_PER_CYCLE(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_we(i_we), .i_size(i_size),
        .i_signed(i_signed), .i_lsb(i_lsb), .i_adr(i_adr), .i_en(i_en), .i_rs2(i_rs2),
        .o_dbus_adr(o_dbus_adr), .o_dbus_dat(o_dbus_dat), .o_dbus_sel(o_dbus_sel),
        .o_dbus_we(o_dbus_we), .o_dbus_cyc(o_dbus_cyc), .i_dbus_rdt(i_dbus_rdt),
        .i_dbus_ack(i_dbus_ack), .o_rd(o_rd), .o_rd_valid(o_rd_valid),
        .o_misalign(o_misalign), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        #1;
        nchecks++; if (o_dbus_cyc !== 1'b0) begin nfail++; $display("FAIL reset_cyc got=%0h exp=0", o_dbus_cyc); end
        nchecks++; if (o_dbus_we !== 1'b0) begin nfail++; $display("FAIL reset_we got=%0h exp=0", o_dbus_we); end
        nchecks++; if (o_rd_valid !== 1'b0) begin nfail++; $display("FAIL reset_rd_valid got=%0h exp=0", o_rd_valid); end
        nchecks++; if (o_misalign !== 1'b0) begin nfail++; $display("FAIL reset_misalign got=%0h exp=0", o_misalign); end
        nchecks++; if (o_done !== 1'b0) begin nfail++; $display("FAIL reset_done got=%0h exp=0", o_done); end
        nchecks++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got=%0h exp=0", o_busy); end
        nchecks++; if (o_rd !== 4'h0) begin nfail++; $display("FAIL reset_rd got=%0h exp=0", o_rd); end
        nchecks++; if (o_dbus_sel !== 4'h0) begin nfail++; $display("FAIL reset_sel got=%0h exp=0", o_dbus_sel); end
        nchecks++; if (o_dbus_adr !== 32'h0) begin nfail++; $display("FAIL reset_adr got=%08h exp=0", o_dbus_adr); end
        nchecks++; if (o_dbus_dat !== 32'h0) begin nfail++; $display("FAIL reset_dat got=%08h exp=0", o_dbus_dat); end
    endtask

    // One full transaction. en_mode: 0 = always enabled, 1 = alternate 1/0, 2 = random.
    task automatic run_op(input string name, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [1:0] lsb, input logic [31:0] adr, input logic [31:0] wdata,
                          input logic [31:0] rdt, input int hold, input int en_mode, input bit noise);
        logic [31:0] exp_dat, exp_val, aligned, got;
        logic [3:0]  exp_sel;
        logic [31:0] exp_adr;
        int          k, it;
        logic        en;

        exp_adr = {adr[31:2], 2'b00};
        aligned = rdt >> (32'(lsb) * 8);
        case (size)
            2'b00: begin
                exp_dat = {4{wdata[7:0]}};
                exp_sel = 4'b0001 << lsb;
                exp_val = (sgn && aligned[7]) ? {24'hFFFFFF, aligned[7:0]} : {24'h0, aligned[7:0]};
            end
            2'b01: begin
                exp_dat = {2{wdata[15:0]}};
                exp_sel = lsb[1] ? 4'b1100 : 4'b0011;
                exp_val = (sgn && aligned[15]) ? {16'hFFFF, aligned[15:0]} : {16'h0, aligned[15:0]};
            end
            default: begin
                exp_dat = wdata;
                exp_sel = 4'b1111;
                exp_val = aligned;
            end
        endcase

        i_start = 1'b1; i_we = we; i_size = size; i_signed = sgn; i_lsb = lsb; i_adr = adr;
        step();
        i_start = 1'b0;
        nchecks++; if (o_busy !== 1'b1) begin nfail++; $display("FAIL %s start_busy got=%0h exp=1", name, o_busy); end
        nchecks++; if (o_done !== 1'b0) begin nfail++; $display("FAIL %s start_done got=%0h exp=0", name, o_done); end
        nchecks++; if (o_misalign !== 1'b0) begin nfail++; $display("FAIL %s start_misalign got=%0h exp=0", name, o_misalign); end

        if (we) begin
            k = 0; it = 0;
            while (k < 8) begin
                en = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? 1'((it % 2) == 0) : 1'($urandom_range(3, 0) != 0);
                if (it > 40) en = 1'b1;
                i_en = en; i_rs2 = wdata[4*k +: 4];
                if (noise) begin i_start = 1'($urandom_range(1, 0)); i_dbus_ack = 1'($urandom_range(1, 0)); end
                #1;
                nchecks++; if (o_dbus_cyc !== 1'b0) begin nfail++; $display("FAIL %s fill_cyc slice=%0d got=%0h exp=0", name, k, o_dbus_cyc); end
                step();
                if (en) k++;
                it++;
            end
            i_en = 1'b0; i_start = 1'b0; i_dbus_ack = 1'b0;
        end

        for (int h = 0; h < hold; h++) begin
            i_dbus_ack = 1'(h == hold - 1);
            i_dbus_rdt = (h == hold - 1) ? rdt : $urandom;
            #1;
            nchecks++; if (o_dbus_cyc !== 1'b1) begin nfail++; $display("FAIL %s bus_cyc cyc=%0d got=%0h exp=1", name, h, o_dbus_cyc); end
            nchecks++; if (o_dbus_we !== we) begin nfail++; $display("FAIL %s bus_we got=%0h exp=%0h", name, o_dbus_we, we); end
            nchecks++; if (o_dbus_adr !== exp_adr) begin nfail++; $display("FAIL %s bus_adr got=%08h exp=%08h", name, o_dbus_adr, exp_adr); end
            nchecks++; if (o_dbus_sel !== exp_sel) begin nfail++; $display("FAIL %s bus_sel got=%0h exp=%0h", name, o_dbus_sel, exp_sel); end
            if (we) begin
                nchecks++; if (o_dbus_dat !== exp_dat) begin nfail++; $display("FAIL %s bus_dat got=%08h exp=%08h", name, o_dbus_dat, exp_dat); end
            end
            step();
        end
        i_dbus_ack = 1'b0; i_dbus_rdt = $urandom;
        #1;
        nchecks++; if (o_dbus_cyc !== 1'b0) begin nfail++; $display("FAIL %s ack_cyc got=%0h exp=0", name, o_dbus_cyc); end
        nchecks++; if (o_dbus_we !== 1'b0) begin nfail++; $display("FAIL %s ack_we got=%0h exp=0", name, o_dbus_we); end
        nchecks++; if (o_dbus_sel !== 4'h0) begin nfail++; $display("FAIL %s ack_sel got=%0h exp=0", name, o_dbus_sel); end
        nchecks++; if (o_done !== we) begin nfail++; $display("FAIL %s ack_done got=%0h exp=%0h", name, o_done, we); end
        nchecks++; if (o_busy !== !we) begin nfail++; $display("FAIL %s ack_busy got=%0h exp=%0h", name, o_busy, !we); end

        if (!we) begin
            k = 0; it = 0; got = 32'h0;
            while (k < 8) begin
                en = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? 1'((it % 2) == 0) : 1'($urandom_range(3, 0) != 0);
                if (it > 40) en = 1'b1;
                i_en = en;
                if (noise) begin i_start = 1'($urandom_range(1, 0)); i_dbus_ack = 1'($urandom_range(1, 0)); end
                #1;
                nchecks++; if (o_rd_valid !== en) begin nfail++; $display("FAIL %s drain_valid slice=%0d got=%0h exp=%0h", name, k, o_rd_valid, en); end
                if (en) got[4*k +: 4] = o_rd;
                else begin
                    nchecks++; if (o_rd !== 4'h0) begin nfail++; $display("FAIL %s drain_idle_rd got=%0h exp=0", name, o_rd); end
                end
                step();
                if (en) k++;
                it++;
            end
            i_en = 1'b0; i_start = 1'b0; i_dbus_ack = 1'b0;
            #1;
            nchecks++; if (got !== exp_val) begin nfail++; $display("FAIL %s load_result got=%08h exp=%08h", name, got, exp_val); end
            nchecks++; if (o_done !== 1'b1) begin nfail++; $display("FAIL %s drain_done got=%0h exp=1", name, o_done); end
            nchecks++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL %s drain_busy got=%0h exp=0", name, o_busy); end
        end
    endtask

    task automatic test_word_store();
        run_op("word_store", 1'b1, 2'b10, 1'b0, 2'd0, 32'h0000_1000, 32'h1234_5678, 32'h0, 3, 0, 1'b0);
        step();
        nchecks++; if (o_done !== 1'b0) begin nfail++; $display("FAIL word_store done_once got=%0h exp=0", o_done); end
        nchecks++; if (o_dbus_cyc !== 1'b0) begin nfail++; $display("FAIL word_store idle_cyc got=%0h exp=0", o_dbus_cyc); end
    endtask

    task automatic test_byte_store();
        run_op("byte_store", 1'b1, 2'b00, 1'b0, 2'd2, 32'h0000_2002, 32'h0000_00AB, 32'h0, 2, 0, 1'b0);
        step();
    endtask

    task automatic test_byte_load();
        run_op("byte_load_s", 1'b0, 2'b00, 1'b1, 2'd3, 32'h0000_3003, 32'h0, 32'h80FF_FFFF, 1, 0, 1'b0);
        step();
        run_op("byte_load_u", 1'b0, 2'b00, 1'b0, 2'd3, 32'h0000_3003, 32'h0, 32'h80FF_FFFF, 2, 0, 1'b0);
        step();
    endtask

    task automatic test_half_load();
        run_op("half_load", 1'b0, 2'b01, 1'b1, 2'd2, 32'h0000_4002, 32'h0, 32'h7FFE_0000, 2, 1, 1'b0);
        step();
    endtask

    task automatic test_misalign();
        logic [1:0] sz [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
        logic [1:0] lb [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2};
        for (int c = 0; c < 6; c++) begin
            i_start = 1'b1; i_we = 1'(c % 2); i_size = sz[c]; i_lsb = lb[c]; i_adr = $urandom;
            step();
            i_start = 1'b0;
            nchecks++; if (o_misalign !== 1'b1) begin nfail++; $display("FAIL misalign_pulse case=%0d got=%0h exp=1", c, o_misalign); end
            nchecks++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL misalign_busy case=%0d got=%0h exp=0", c, o_busy); end
            nchecks++; if (o_dbus_cyc !== 1'b0) begin nfail++; $display("FAIL misalign_cyc case=%0d got=%0h exp=0", c, o_dbus_cyc); end
            step();
            nchecks++; if (o_misalign !== 1'b0) begin nfail++; $display("FAIL misalign_once case=%0d got=%0h exp=0", c, o_misalign); end
            nchecks++; if ((o_dbus_cyc | o_busy | o_done) !== 1'b0) begin nfail++; $display("FAIL misalign_quiet case=%0d cyc=%0h busy=%0h done=%0h exp=0", c, o_dbus_cyc, o_busy, o_done); end
        end
    endtask

    task automatic test_reset_mid();
        i_start = 1'b1; i_we = 1'b0; i_size = 2'b10; i_signed = 1'b0; i_lsb = 2'd0; i_adr = 32'h0000_5000;
        step();
        i_start = 1'b0;
        nchecks++; if (o_dbus_cyc !== 1'b1) begin nfail++; $display("FAIL rstmid_cyc_before got=%0h exp=1", o_dbus_cyc); end
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0; i_dbus_ack = 1'b1; i_dbus_rdt = 32'hDEAD_BEEF;
        #1;
        nchecks++; if (o_dbus_cyc !== 1'b0) begin nfail++; $display("FAIL rstmid_cyc got=%0h exp=0", o_dbus_cyc); end
        nchecks++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL rstmid_busy got=%0h exp=0", o_busy); end
        nchecks++; if (o_dbus_adr !== 32'h0) begin nfail++; $display("FAIL rstmid_adr got=%08h exp=0", o_dbus_adr); end
        step();
        i_dbus_ack = 1'b0; i_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            nchecks++; if (o_done !== 1'b0) begin nfail++; $display("FAIL rstmid_done cyc=%0d got=%0h exp=0", c, o_done); end
            nchecks++; if (o_rd_valid !== 1'b0) begin nfail++; $display("FAIL rstmid_rd_valid cyc=%0d got=%0h exp=0", c, o_rd_valid); end
            nchecks++; if ((o_dbus_cyc | o_busy) !== 1'b0) begin nfail++; $display("FAIL rstmid_idle cyc=%0d cyc=%0h busy=%0h exp=0", c, o_dbus_cyc, o_busy); end
            step();
        end
        i_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_op("b2b_store", 1'b1, 2'b01, 1'b0, 2'd2, 32'h0000_6002, 32'hCAFE_1357, 32'h0, 1, 0, 1'b0);
        run_op("b2b_load", 1'b0, 2'b01, 1'b1, 2'd0, 32'h0000_6000, 32'h0, 32'h1234_8001, 1, 0, 1'b0);
        run_op("b2b_word_load", 1'b0, 2'b11, 1'b1, 2'd0, 32'h0000_6004, 32'h0, 32'h8765_4321, 2, 2, 1'b1);
        step();
    endtask

    task automatic test_random();
        logic       we, sgn;
        logic [1:0] size, lsb;
        for (int n = 0; n < 30; n++) begin
            we   = 1'($urandom_range(1, 0));
            sgn  = 1'($urandom_range(1, 0));
            size = 2'($urandom_range(3, 0));
            lsb  = 2'($urandom_range(3, 0));
            if (size == 2'b01) lsb[0] = 1'b0;
            else if (size[1]) lsb = 2'd0;
            run_op($sformatf("rand%0d", n), we, size, sgn, lsb, $urandom, $urandom, $urandom,
                   $urandom_range(4, 1), 2, 1'b1);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_byte_load();
        test_half_load();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
